// File: rtl/tpu_seq_ctrl_pkg.sv
// Shared types and helpers for the systolic-array sequencer and its feeders.
package tpu_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_C = 2'd0,
        OP_MATMUL = 2'd1,
        OP_READ_C = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_COMP = 3'd2,
        ST_READ = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Terminal counter value; MATMUL adds DIM-1 drain steps beyond the 2*DIM-1 skewed feed.
    function automatic int unsigned steps_for(op_t op, int unsigned dim);
        case (op)
            OP_MATMUL: return 3 * dim - 3;
            OP_LOAD_C,
            OP_READ_C: return dim - 1;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/tpu_seq_ctrl_if.sv
// Command and array-control bundle between host/feeders (master) and sequencer (slave).
interface tpu_seq_ctrl_if
    import tpu_seq_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int ROW_W = $clog2(DIM),
    parameter int CNT_W = $clog2(3 * DIM - 1)
);
    logic             start;
    op_t              op;
    logic             stall;
    logic             busy;
    logic             done;
    logic             err;
    logic             mac_en;
    logic             mac_wren;
    logic [DIM-1:0]   row_wr;
    logic [DIM-1:0]   row_rd;
    logic [ROW_W-1:0] row_idx;
    logic             fetch_en;
    logic [CNT_W-1:0] k_idx;
    logic [DIM-1:0]   lane_valid;

    modport master (
        output start, op, stall,
        input  busy, done, err, mac_en, mac_wren, row_wr, row_rd,
               row_idx, fetch_en, k_idx, lane_valid
    );

    modport slave (
        input  start, op, stall,
        output busy, done, err, mac_en, mac_wren, row_wr, row_rd,
               row_idx, fetch_en, k_idx, lane_valid
    );
endinterface

// File: rtl/tpu_seq_ctrl_skew_mask.sv
// Maps the streaming step t to the feeder lanes carrying real data (lane i is delayed by i).
module tpu_skew_mask #(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(3 * DIM - 1)
) (
    input  logic [CNT_W-1:0] t_i,
    output logic [DIM-1:0]   lane_valid_o
);
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            // One extra bit so t < gi shows up as a set sign bit instead of wrapping.
            logic [CNT_W:0] diff;
            assign diff = {1'b0, t_i} - (CNT_W+1)'(gi);
            assign lane_valid_o[gi] = !diff[CNT_W] && (diff < (CNT_W+1)'(DIM));
        end
    endgenerate
endmodule

// File: rtl/tpu_seq_ctrl.sv
// Sequencer for a DIM x DIM tpumac systolic array: C preload, skewed matmul stream, C readout.
module tpu_seq_ctrl
    import tpu_seq_pkg::*;
#(
    parameter int DIM = 8
) (
    input  logic          clk,
    input  logic          rst,
    tpu_seq_ctrl_if.slave bus
);
    localparam int ROW_W = $clog2(DIM);
    localparam int CNT_W = $clog2(3 * DIM - 1);

    state_t           state_q;
    op_t              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_last;
    logic [DIM-1:0]   mask;
    logic [DIM-1:0]   row_oh;

    assign cnt_last = CNT_W'(steps_for(op_q, DIM));
    assign row_oh   = DIM'(1) << cnt_q;

    tpu_skew_mask #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) u_skew (
        .t_i          (cnt_q),
        .lane_valid_o (mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD_C;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.op;
                        cnt_q <= '0;
                        case (bus.op)
                            OP_LOAD_C: state_q <= ST_LOAD;
                            OP_MATMUL: state_q <= ST_COMP;
                            OP_READ_C: state_q <= ST_READ;
                            default:   state_q <= ST_DONE;
                        endcase
                    end
                end
                ST_LOAD, ST_COMP, ST_READ: begin
                    if (!bus.stall) begin
                        if (cnt_q == cnt_last) begin
                            state_q <= ST_DONE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall only masks the strobes; indices keep showing the held counter.
    always_comb begin
        bus.busy       = (state_q != ST_IDLE);
        bus.done       = 1'b0;
        bus.err        = 1'b0;
        bus.mac_en     = 1'b0;
        bus.mac_wren   = 1'b0;
        bus.row_wr     = '0;
        bus.row_rd     = '0;
        bus.row_idx    = '0;
        bus.fetch_en   = 1'b0;
        bus.k_idx      = '0;
        bus.lane_valid = '0;
        case (state_q)
            ST_LOAD: begin
                bus.mac_en   = !bus.stall;
                bus.mac_wren = !bus.stall;
                bus.row_wr   = bus.stall ? '0 : row_oh;
                bus.row_idx  = cnt_q[ROW_W-1:0];
            end
            ST_COMP: begin
                bus.mac_en     = !bus.stall;
                bus.k_idx      = cnt_q;
                bus.lane_valid = mask;
                bus.fetch_en   = (|mask) && !bus.stall;
            end
            ST_READ: begin
                bus.row_rd  = bus.stall ? '0 : row_oh;
                bus.row_idx = cnt_q[ROW_W-1:0];
            end
            ST_DONE: begin
                bus.done = 1'b1;
                bus.err  = (op_q == OP_RSVD);
            end
            default: ;
        endcase
    end
endmodule
